best_match_compare: RTL



---
 rtl/best_match_compare.sv | 139 +++++++++++++
 1 files changed

// File: rtl/best_match_compare.sv
// Best-match tracker for the motion-estimation array: keeps the minimum
// distortion and its motion vector over one full candidate search.
module best_match_compare #(
  parameter int NUM_PE     = 16,
  parameter int DIST_W     = 8,
  parameter int VEC_W      = 4,
  parameter int CAND_TOTAL = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     CompStart,
  input  logic [NUM_PE-1:0]        PEready,
  input  logic [NUM_PE*DIST_W-1:0] PEout,
  input  logic [VEC_W-1:0]         VectorX,
  input  logic [VEC_W-1:0]         VectorY,
  output logic [DIST_W-1:0]        BestDist,
  output logic [VEC_W-1:0]         MotionX,
  output logic [VEC_W-1:0]         MotionY,
  output logic                     done,
  output logic                     multi_err
);

  localparam int CNT_W = $clog2(CAND_TOTAL) + 1;
  localparam logic [CNT_W-1:0] CAND_LAST = CNT_W'(CAND_TOTAL - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [DIST_W-1:0] best_reg, best_next;
  logic [VEC_W-1:0]  mx_reg, mx_next;
  logic [VEC_W-1:0]  my_reg, my_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              done_reg, done_next;
  logic              merr_reg, merr_next;

  // Isolate the lowest set strobe; anything left over means a multi-hit.
  logic [NUM_PE-1:0] lowest_onehot;
  logic              multi_hit;
  logic              any_hit;

  assign lowest_onehot = PEready & (~PEready + NUM_PE'(1));
  assign multi_hit     = |(PEready & (PEready - NUM_PE'(1)));
  assign any_hit       = |PEready;

  logic [DIST_W-1:0] lane_masked [NUM_PE];
  logic [DIST_W-1:0] sel_dist;

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
      assign lane_masked[gi] = PEout[gi*DIST_W +: DIST_W] & {DIST_W{lowest_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_dist = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      sel_dist = sel_dist | lane_masked[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    best_next  = best_reg;
    mx_next    = mx_reg;
    my_next    = my_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    merr_next  = merr_reg;
    case (state_reg)
      IDLE: begin
        if (CompStart) begin
          state_next = SEARCH;
          best_next  = '1;
          mx_next    = '0;
          my_next    = '0;
          cnt_next   = '0;
          merr_next  = 1'b0;
        end
      end
      SEARCH: begin
        if (!CompStart) begin
          state_next = IDLE;
        end else if (any_hit) begin
          cnt_next = cnt_reg + CNT_W'(1);
          // Strict compare: ties and all-ones candidates keep the incumbent.
          if (sel_dist < best_reg) begin
            best_next = sel_dist;
            mx_next   = VectorX;
            my_next   = VectorY;
          end
          if (multi_hit) begin
            merr_next = 1'b1;
          end
          if (cnt_reg == CAND_LAST) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!CompStart) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      best_reg  <= '1;
      mx_reg    <= '0;
      my_reg    <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      merr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      best_reg  <= best_next;
      mx_reg    <= mx_next;
      my_reg    <= my_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      merr_reg  <= merr_next;
    end
  end

  assign BestDist  = best_reg;
  assign MotionX   = mx_reg;
  assign MotionY   = my_reg;
  assign done      = done_reg;
  assign multi_err = merr_reg;

endmodule
